// File: rtl/vco_period_scheduler.sv
// vco_period_scheduler
// Round-robin scheduler that shares one external natural_log unit and one
// period multiplier across CHANNELS 555-style VCO voices. Each visit turns a
// channel's control voltage into a high-phase length in clk cycles.
// Optional feature macro: VCO_SCHED_CHANGE_DETECT_EN
//   defined   -> a channel is recomputed only when its clamped input moved
//                (or it has never been written); otherwise the FSM idles.
//   undefined -> every channel is recomputed continuously.

module vco_period_scheduler #(
  parameter int CLOCK_RATE   = 50000000,
  parameter int CHANNELS     = 4,
  parameter int R1           = 47000,
  parameter int R2           = 27000,
  parameter int C_35_SHIFTED = 1134,
  parameter int LOG_LATENCY  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [16*CHANNELS-1:0]   v_control,
  output logic [23:0]              log_arg,
  input  logic [11:0]              log_result,
  output logic [32*CHANNELS-1:0]   cycles_high,
  output logic [CHANNELS-1:0]      valid,
  output logic [CHANNELS-1:0]      upd_strobe,
  output logic                     busy
);

  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = $clog2(LOG_LATENCY + 1);

  // C*(R1+R2)*CLOCK_RATE folded into one constant; C carries a 2^35 scale and
  // log_result an 2^8 scale, so the product is shifted right by 43 later.
  localparam logic [71:0] SCALE_K =
    72'(C_35_SHIFTED) * 72'(R1 + R2) * 72'(CLOCK_RATE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG,
    S_WAIT,
    S_SCALE,
    S_WRITE
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_sel;
  logic [15:0]     r_vsel;
  logic [CW-1:0]   r_wait;
  logic [31:0]     r_res;

  logic [15:0]     w_vraw;
  logic [15:0]     w_vclamp;
  logic            w_eligible;
  logic [19:0]     w_num;
  logic [19:0]     w_den;
  logic [19:0]     w_quot;
  logic [23:0]     w_argNext;
  logic [71:0]     w_prod;
  logic [71:0]     w_shifted;
  logic [31:0]     w_res;

  // Input of the channel under the pointer, clamped so VCC - v never hits zero
  assign w_vraw   = v_control[16*r_ptr +: 16];
  assign w_vclamp = (w_vraw == 16'hFFFF) ? 16'hFFFE : w_vraw;

`ifdef VCO_SCHED_CHANGE_DETECT_EN
  logic [15:0] r_lastv [CHANNELS];

  assign w_eligible = !valid[r_ptr] || (w_vclamp != r_lastv[r_ptr]);

  // Remember the clamped voltage each channel was last computed from
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_lastv[k] <= '0;
      end
    end else if (r_state == S_WRITE) begin
      r_lastv[r_sel] <= r_vsel;
    end
  end
`else
  assign w_eligible = 1'b1;
`endif

  // Log argument 1 + v/(2(VCC-v)) in 8.8-ish fixed point: (16 + 16v/(2(65535-v)))*16
  assign w_num     = {r_vsel, 4'b0000};
  assign w_den     = {3'b000, (16'hFFFF - r_vsel), 1'b0};
  assign w_quot    = w_num / w_den;
  assign w_argNext = {w_quot + 20'd16, 4'b0000};

  // Period scaling with saturation to 32 bits
  assign w_prod    = SCALE_K * {60'd0, log_result};
  assign w_shifted = w_prod >> 43;
  assign w_res     = (|w_shifted[71:32]) ? 32'hFFFF_FFFF : w_shifted[31:0];

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(CHANNELS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scheduler FSM: one slot per eligible channel, all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_sel       <= '0;
      r_vsel      <= '0;
      r_wait      <= '0;
      r_res       <= '0;
      log_arg     <= '0;
      cycles_high <= '0;
      valid       <= '0;
      upd_strobe  <= '0;
      busy        <= 1'b0;
    end else begin
      upd_strobe <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_eligible) begin
            r_sel   <= r_ptr;
            r_vsel  <= w_vclamp;
            r_state <= S_ARG;
            busy    <= 1'b1;
          end else begin
            r_ptr   <= nextPtr(r_ptr);
          end
        end
        S_ARG: begin
          log_arg <= w_argNext;
          r_wait  <= CW'(LOG_LATENCY);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wait <= r_wait - 1'b1;
          if (r_wait == CW'(1)) begin
            r_state <= S_SCALE;
          end
        end
        S_SCALE: begin
          r_res   <= w_res;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          cycles_high[32*r_sel +: 32] <= r_res;
          valid[r_sel]                <= 1'b1;
          upd_strobe[r_sel]           <= 1'b1;
          r_ptr                       <= nextPtr(r_sel);
          r_state                     <= S_IDLE;
          busy                        <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vco_period_scheduler.sv
// tb_vco_period_scheduler
// Directed, table-driven bench for vco_period_scheduler at default parameters.
// Models the external natural_log unit as a LOG_LATENCY-deep delay line.
// Covers both builds of VCO_SCHED_CHANGE_DETECT_EN.

module tb_vco_period_scheduler;

  localparam int CH  = 4;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              resetN;
  logic [16*CH-1:0]  vControl;
  logic [23:0]       logArg;
  logic [11:0]       logResult;
  logic [32*CH-1:0]  cyclesHigh;
  logic [CH-1:0]     validOut;
  logic [CH-1:0]     updStrobe;
  logic              busyOut;

  int total   = 0;
  int bad     = 0;
  int elapsed = 0;

  typedef struct {
    int          chan;
    logic [15:0] v;
    logic [23:0] expArg;
    logic [31:0] expCycles;
  } vec_t;

  vec_t vecs [CH];

  vco_period_scheduler dut (
    .clk         (clk),
    .reset_n     (resetN),
    .v_control   (vControl),
    .log_arg     (logArg),
    .log_result  (logResult),
    .cycles_high (cyclesHigh),
    .valid       (validOut),
    .upd_strobe  (updStrobe),
    .busy        (busyOut)
  );

  // 100 MHz bench clock
  always #5 clk = ~clk;

  // Rounded ln(arg/256)*256, i.e. the log unit's 8-fractional-bit output
  function automatic logic [11:0] logModel(input logic [23:0] arg);
    real r;
    if (arg < 24'd256) return 12'd0;
    r = $ln(real'(arg) / 256.0) * 256.0 + 0.5;
    return 12'($rtoi(r));
  endfunction

  // Log unit model: result appears LAT cycles after the argument changes
  logic [11:0] logPipe [LAT];
  always @(posedge clk) begin
    logPipe[0] <= logModel(logArg);
    for (int i = 1; i < LAT; i++) logPipe[i] <= logPipe[i-1];
  end
  assign logResult = logPipe[LAT-1];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < CH; k++) vControl[16*vecs[k].chan +: 16] = vecs[k].v;
  endtask

  task automatic tick();
    @(negedge clk);
    elapsed++;
  endtask

  task automatic waitStrobe(input int maxCycles, output logic [CH-1:0] seen);
    seen = '0;
    for (int i = 0; i < maxCycles; i++) begin
      tick();
      if (updStrobe != '0) begin
        seen = updStrobe;
        break;
      end
    end
  endtask

  // Hard stop in case a wait ever escapes its bound
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [CH-1:0] seen;
    logic [CH-1:0] oneHot;
    int            sCount;
    int            bCount;
    int            otherCount;

    vecs[0] = '{0, 16'd0,     24'd256,     32'd0};
    vecs[1] = '{1, 16'hFFFF,  24'd8388608, 32'd1269793};
    vecs[2] = '{2, 16'd32768, 24'd384,     32'd49608};
    vecs[3] = '{3, 16'd16384, 24'd288,     32'd14310};

    resetN   = 1'b0;
    vControl = '0;
    applyStimulus();
    repeat (3) @(negedge clk);

    checkOutput("reset cycles_high", cyclesHigh, 0);
    checkOutput("reset valid", validOut, 0);
    checkOutput("reset log_arg", logArg, 0);
    checkOutput("reset upd_strobe", updStrobe, 0);
    checkOutput("reset busy", busyOut, 0);

    resetN  = 1'b1;
    elapsed = 0;

    // First pass: channels in order, one 6-cycle slot each
    for (int i = 0; i < CH; i++) begin
      waitStrobe(20, seen);
      oneHot = '0;
      oneHot[vecs[i].chan] = 1'b1;
      checkOutput($sformatf("pass1 strobe ch%0d", vecs[i].chan), seen, oneHot);
      checkOutput($sformatf("pass1 time ch%0d", vecs[i].chan), elapsed, 6 * (vecs[i].chan + 1));
      checkOutput($sformatf("pass1 log_arg ch%0d", vecs[i].chan), logArg, vecs[i].expArg);
      checkOutput($sformatf("pass1 cycles ch%0d", vecs[i].chan),
                  cyclesHigh[32*vecs[i].chan +: 32], vecs[i].expCycles);
    end
    checkOutput("valid after pass1", validOut, 4'b1111);

`ifdef VCO_SCHED_CHANGE_DETECT_EN
    // Steady inputs: scheduler must stay quiet
    sCount = 0;
    bCount = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (updStrobe != '0) sCount++;
      if (busyOut) bCount++;
    end
    checkOutput("steady strobes", sCount, 0);
    checkOutput("steady busy cycles", bCount, 0);

    // Moving channel 3 alone gives exactly one refresh of channel 3
    vControl[63:48] = 16'd100;
    sCount     = 0;
    otherCount = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (updStrobe[3]) sCount++;
      if (updStrobe[2:0] != '0) otherCount++;
    end
    checkOutput("ch3 change strobes", sCount, 1);
    checkOutput("other channel strobes", otherCount, 0);
    checkOutput("ch3 change log_arg", logArg, 256);
    checkOutput("ch3 change cycles", cyclesHigh[127:96], 0);
    checkOutput("ch3 change busy", busyOut, 0);
`else
    // Continuous mode: wrap back to channel 0 on the next 6-cycle slot
    waitStrobe(20, seen);
    checkOutput("wrap strobe ch0", seen, 4'b0001);
    checkOutput("wrap time ch0", elapsed, 30);
    sCount = 0;
    bCount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (updStrobe != '0) sCount++;
      if (!busyOut) bCount++;
    end
    checkOutput("continuous strobes in 12 cycles", sCount, 2);
    checkOutput("continuous idle cycles in 12", bCount, 2);
`endif

    // Reset in the middle of channel 1's WAIT, with a nonzero channel 0 result
    vControl[15:0] = 16'd32768;
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN  = 1'b1;
    elapsed = 0;
    repeat (9) tick();
    checkOutput("pre-abort busy", busyOut, 1);
    checkOutput("pre-abort valid", validOut, 4'b0001);
    checkOutput("pre-abort cycles ch0", cyclesHigh[31:0], 49608);
    checkOutput("pre-abort log_arg", logArg, 8388608);
    resetN = 1'b0;
    #1;
    checkOutput("abort cycles_high", cyclesHigh, 0);
    checkOutput("abort valid", validOut, 0);
    checkOutput("abort log_arg", logArg, 0);
    checkOutput("abort busy", busyOut, 0);
    checkOutput("abort upd_strobe", updStrobe, 0);
    @(negedge clk);
    resetN  = 1'b1;
    elapsed = 0;
    waitStrobe(20, seen);
    checkOutput("restart strobe ch0", seen, 4'b0001);
    checkOutput("restart time ch0", elapsed, 6);
    checkOutput("restart cycles ch0", cyclesHigh[31:0], 49608);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
